inst_prefetch_buf: RTL and testbench
====================================

// Module: inst_prefetch_buf
// PURPOSE
//   Instruction prefetch queue between the instruction-memory port (iaddr/idata/iready_n)
//   and the core fetch stage. Issues sequential word fetches ahead of the fetch stage.
//   Buffers {pc, inst} pairs in a FIFO and hands them to fetch with a valid/deq handshake.
//   Flushes and restarts at a new PC on a redirect from branch-miss or BTB.
// PARAMETERS
//   DEPTH     4            FIFO entries; power of 2, >= 2
//   RESET_PC  32'h0000_0000 first fetch address after reset
//   PTR_W     $clog2(DEPTH) pointer width (derived, localparam)
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous reset, active-high
//   iaddr          out  32  instruction-memory address of outstanding fetch
//   ireq           out  1   fetch request active (queue not full)
//   idata          in   32  instruction word, valid when iready_n==0
//   iready_n       in   1   active-low: idata valid for current iaddr this cycle
//   redirect       in   1   flush queue, restart fetch at redirect_pc
//   redirect_pc    in   32  new fetch PC, word aligned
//   deq            in   1   fetch stage consumes head entry this cycle
//   out_valid      out  1   head entry valid
//   out_inst       out  32  head instruction
//   out_pc         out  32  PC of head instruction
//   count          out  PTR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (async): iaddr=RESET_PC, count=0, rd/wr ptr=0, out_valid=0, out_inst=0, out_pc=0.
// - Request: ireq = (count != DEPTH) && !redirect. iaddr is held stable until accepted.
// - Accept: at a rising edge with ireq==1 and iready_n==0:
//   - {iaddr, idata} written at wr_ptr; wr_ptr++ (wraps mod DEPTH).
//   - iaddr <= iaddr+4 (32-bit wrap 0xFFFF_FFFC -> 0).
// - iready_n==0 while ireq==0 is ignored; iaddr is not advanced.
// - Dequeue: at an edge with deq==1 and count!=0, rd_ptr++ (wraps). deq while empty is ignored.
// - Simultaneous accept and dequeue: count unchanged; both pointers advance.
//   A full queue does not accept, even if deq==1 the same cycle (no combinational full bypass).
// - out_valid = (count!=0); out_inst/out_pc are the head entry, combinational from the array.
//   out_inst/out_pc read 0 when empty.
// - Redirect (highest priority): at the edge, count=0, ptrs=0, iaddr<=redirect_pc.
//   - Any same-cycle memory response is discarded; same-cycle deq is ignored.
//   - out_valid is 0 in the cycle after redirect.
// - Redirect with misaligned redirect_pc: low 2 bits forced to 0.
// - Latency: a word accepted at edge N is visible on out_* after edge N (one cycle), no bypass.
// - Throughput: 1 word/cycle when iready_n stays low and fetch dequeues every cycle.
// - No internal FSM beyond the FIFO. State = {iaddr, ptrs, count, array}.
// CONFIGURATION
//   PREFETCH_BYPASS_EN defined:
//   - When count==0 && ireq && !iready_n && !redirect, out_valid=1 combinationally.
//   - out_inst=idata, out_pc=iaddr in that cycle (zero-latency).
//   - If deq==1 that cycle, the word is consumed and NOT written; wr_ptr unchanged; iaddr+=4.
//   - If deq==0, the word is written as normal.
//   PREFETCH_BYPASS_EN undefined: no combinational path from idata/iready_n to out_*.
//   - Minimum one-cycle latency as described above.
// TESTING
//   1 Reset: assert rst mid-run with count=3 -> immediately count=0, out_valid=0, iaddr=RESET_PC.
//   2 Stream: iready_n=0 always, deq=1 always, RESET_PC=0 -> out_pc 0,4,8,... one per cycle
//     after 1st; out_inst matches memory model.
//   3 Full: deq=0, iready_n=0 -> count reaches 4, ireq=0, iaddr held at 0x10.
//     Then one deq -> next cycle accept of 0x10.
//   4 Redirect: queue holds 0x0..0xC, assert redirect with redirect_pc=0x200 and iready_n=0
//     -> next cycle count=0, iaddr=0x200, response dropped; next accept pc=0x200.
//   5 Stalled memory: iready_n=1 for 5 cycles with deq=1 on empty queue
//     -> count stays 0, iaddr unchanged, no underflow.
//   6 PREFETCH_BYPASS_EN: empty queue, iready_n=0, idata=0x00500093, deq=1
//     -> same-cycle out_valid=1, out_inst=0x00500093, count stays 0.

Source files
------------

// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf: instruction prefetch queue between the instruction-memory
// port and the core fetch stage. Fetches sequential words ahead of the fetch
// stage, buffers {pc, inst} pairs in a DEPTH-entry FIFO and presents the head
// entry with a valid/deq handshake. A redirect flushes the queue and restarts
// fetching at a new word-aligned PC.
//
// Optional feature: define PREFETCH_BYPASS_EN to add a zero-latency path that
// presents an incoming memory word directly on out_* while the queue is empty.
// Without it, a fetched word reaches out_* one cycle after it is accepted.
module inst_prefetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      iaddr,
  output logic             ireq,
  input  logic [31:0]      idata,
  input  logic             iready_n,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             deq,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   LP_CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Control state
  logic [31:0]      r_iaddr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Storage (data only, never reset)
  logic [31:0]      r_pc_mem   [DEPTH];
  logic [31:0]      r_inst_mem [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_ireq;
  logic             w_accept;
  logic             w_bypass;
  logic             w_consume;
  logic             w_write;
  logic             w_pop;
  logic [31:0]      w_iaddr_inc;
  logic [31:0]      w_redirect_aligned;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);

  // A full queue never requests, even if the head is being dequeued this
  // cycle: there is deliberately no combinational full-bypass path.
  assign w_ireq   = !w_full && !redirect;
  assign w_accept = w_ireq && !iready_n;

`ifdef PREFETCH_BYPASS_EN
  // Empty queue with a word arriving: show it on out_* this cycle. If fetch
  // takes it right away it never enters the FIFO.
  assign w_bypass  = w_empty && w_accept;
  assign w_consume = w_bypass && deq;
`else
  assign w_bypass  = 1'b0;
  assign w_consume = 1'b0;
`endif

  assign w_write = w_accept && !w_consume;
  // Dequeue only a real stored entry; redirect overrides any same-cycle deq.
  assign w_pop   = deq && !w_empty && !redirect;

  // Sequential fetch address, wrapping naturally at 2^32.
  assign w_iaddr_inc        = r_iaddr + 32'd4;
  assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Fetch address, FIFO pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iaddr  <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_iaddr  <= w_redirect_aligned;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_iaddr <= w_iaddr_inc;
      end
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the accepted {pc, inst} pair at the write pointer.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_pc_mem[r_wr_ptr]   <= r_iaddr;
      r_inst_mem[r_wr_ptr] <= idata;
    end
  end

  // Head-of-queue presentation; zeros when nothing is valid.
  always_comb begin
    out_valid = !w_empty || w_bypass;
    out_inst  = 32'h0;
    out_pc    = 32'h0;
    if (!w_empty) begin
      out_inst = r_inst_mem[r_rd_ptr];
      out_pc   = r_pc_mem[r_rd_ptr];
    end else if (w_bypass) begin
      out_inst = idata;
      out_pc   = r_iaddr;
    end
  end

  assign iaddr = r_iaddr;
  assign ireq  = w_ireq;
  assign count = r_count;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed testbench for inst_prefetch_buf (DEPTH=4, RESET_PC=0).
module tb_inst_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic        ireq;
  logic [31:0] idata;
  logic        iready_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  inst_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .ireq(ireq), .idata(idata),
    .iready_n(iready_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .deq(deq), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        d;
    logic        r;
    logic [31:0] rpc;
    logic        e_ireq;
    logic [2:0]  e_cnt;
    logic [31:0] e_iaddr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  function automatic vec_t mk(input logic rn, d, r, input logic [31:0] rpc,
                              input logic e_ireq, input logic [2:0] e_cnt,
                              input logic [31:0] e_iaddr, input logic e_vld,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rn = rn; v.d = d; v.r = r; v.rpc = rpc; v.e_ireq = e_ireq;
    v.e_cnt = e_cnt; v.e_iaddr = e_iaddr; v.e_vld = e_vld; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model answers for whatever address is currently presented.
  task automatic drive(input logic rn, input logic d, input logic r, input logic [31:0] rpc);
    iready_n    = rn;
    deq         = d;
    redirect    = r;
    redirect_pc = rpc;
    idata       = mem_word(iaddr);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // rn d r rpc | ireq cnt iaddr vld pc
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 3'd0, 32'h000, 1'b0, 32'h000);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 32'h004, 1'b1, 32'h000);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd2, 32'h008, 1'b1, 32'h000);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd3, 32'h00C, 1'b1, 32'h000);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd4, 32'h010, 1'b1, 32'h000);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 3'd4, 32'h010, 1'b1, 32'h000);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 3'd3, 32'h010, 1'b1, 32'h004);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd4, 32'h014, 1'b1, 32'h004);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 3'd0, 32'h200, 1'b0, 32'h000);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 32'h204, 1'b1, 32'h200);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 3'd0, 32'h204, 1'b0, 32'h000);
    for (int i = 11; i < 16; i++)
      tbl[i] = mk(1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 3'd0, 32'h204, 1'b0, 32'h000);
`ifdef PREFETCH_BYPASS_EN
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd0, 32'h208, 1'b0, 32'h000);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd0, 32'h20C, 1'b0, 32'h000);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd0, 32'h210, 1'b0, 32'h000);
`else
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 32'h208, 1'b1, 32'h204);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 32'h20C, 1'b1, 32'h208);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 32'h210, 1'b1, 32'h20C);
`endif

    // Reset state
    iaddr_init: begin
      iready_n = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; idata = 32'h0;
    end
    rst = 1'b1;
    #12;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_ireq", 32'(ireq), 32'h1);

    // Asynchronous reset mid-run with three entries queued
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("midrst_pre_count", 32'(count), 32'h3);
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_iaddr", iaddr, 32'h0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: fill to full, full+deq, redirect (misaligned), stalled memory, stream
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rn, tbl[i].d, tbl[i].r, tbl[i].rpc);
      #1;
      chk($sformatf("v%0d_ireq", i), 32'(ireq), 32'(tbl[i].e_ireq));
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_iaddr", i), iaddr, tbl[i].e_iaddr);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("v%0d_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_inst", i), out_inst, mem_word(tbl[i].e_pc));
      end else begin
        chk($sformatf("v%0d_pc0", i), out_pc, 32'h0);
        chk($sformatf("v%0d_inst0", i), out_inst, 32'h0);
      end
    end

    // Continuous stream: memory always ready, fetch dequeues every cycle
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      chk($sformatf("s%0d_valid", k), 32'(out_valid), 32'h1);
`ifdef PREFETCH_BYPASS_EN
      chk($sformatf("s%0d_count", k), 32'(count), 32'h0);
      chk($sformatf("s%0d_pc", k), out_pc, 32'(4 * k));
      chk($sformatf("s%0d_inst", k), out_inst, mem_word(32'(4 * k)));
`else
      chk($sformatf("s%0d_count", k), 32'(count), 32'h1);
      chk($sformatf("s%0d_pc", k), out_pc, 32'(4 * (k - 1)));
      chk($sformatf("s%0d_inst", k), out_inst, mem_word(32'(4 * (k - 1))));
`endif
    end

    // Empty queue, word arriving with deq: bypass vs. one-cycle latency
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    idata = 32'h0050_0093;
    #1;
`ifdef PREFETCH_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 32'h1);
    chk("byp_inst", out_inst, 32'h0050_0093);
    chk("byp_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("byp_count", 32'(count), 32'h0);
    chk("byp_iaddr", iaddr, 32'h4);
`else
    chk("nobyp_valid", 32'(out_valid), 32'h0);
    chk("nobyp_inst", out_inst, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("nobyp_count", 32'(count), 32'h1);
    chk("nobyp_pc", out_pc, 32'h0);
    chk("nobyp_inst_late", out_inst, 32'h0050_0093);
    chk("nobyp_iaddr", iaddr, 32'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
